// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory block arbiter.
package mem_arb_pkg;

  localparam int BLK_W   = 256;
  localparam int BLK_OFF = 5;

  typedef enum logic [2:0] {
    IDLE,
    I_RD,
    D_RD,
    D_WR,
    DONE
  } arb_state_t;

  typedef enum logic [1:0] {
    REQ_I   = 2'd0,
    REQ_DRD = 2'd1,
    REQ_DWR = 2'd2
  } req_id_t;

  function automatic logic [31:0] blk_align(input logic [31:0] addr);
    return {addr[31:BLK_OFF], {BLK_OFF{1'b0}}};
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: one-hot grant from masked requests and the last winner.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic       last_i,
  output logic [2:0] grant
);

  logic       d_any;
  logic [2:0] d_grant;

  assign d_any = req[REQ_DRD] | req[REQ_DWR];

  // Writebacks go before refills so a dirty line leaves before its replacement arrives
  always_comb begin
    d_grant = 3'b000;
    if (req[REQ_DWR]) begin
      d_grant[REQ_DWR] = 1'b1;
    end else if (req[REQ_DRD]) begin
      d_grant[REQ_DRD] = 1'b1;
    end
  end

  // I wins unless D also wants the port and I was the previous winner
  always_comb begin
    grant = 3'b000;
    if (req[REQ_I] && (!d_any || !last_i)) begin
      grant[REQ_I] = 1'b1;
    end else begin
      grant = d_grant;
    end
  end

endmodule

// File: rtl/mem_block_arbiter.sv
// Serialises I-cache refills and D-cache refills/writebacks onto the single memory block port.
module mem_block_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_done,
  output logic [BLK_W-1:0] i_rdata,
  input  logic             d_rd_req,
  input  logic             d_wr_req,
  input  logic [31:0]      d_rd_addr,
  input  logic [31:0]      d_wr_addr,
  input  logic [BLK_W-1:0] d_wdata,
  output logic             d_rd_done,
  output logic             d_wr_done,
  output logic [BLK_W-1:0] d_rdata,
  output logic [31:0]      mem_addr,
  output logic             mem_blk_read,
  output logic             mem_blk_write,
  output logic [BLK_W-1:0] mem_wdata,
  input  logic [BLK_W-1:0] mem_rdata,
  input  logic             mem_read_valid,
  input  logic             mem_write_valid,
  output logic             arb_idle,
  output logic             arb_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  arb_state_t       state;
  arb_state_t       state_next;
  req_id_t          cur_id;
  req_id_t          grant_id;
  logic             last_i;
  logic [2:0]       mask;
  logic [2:0]       raw_req;
  logic [2:0]       masked_req;
  logic [2:0]       grant;
  logic [31:0]      grant_addr;
  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;
  logic             waiting;
  logic             take_grant;
  logic             timeout_hit;

  assign raw_req    = {d_wr_req, d_rd_req, i_req};
  assign masked_req = raw_req & ~mask;

  mem_arb_pick u_pick (
    .req    (masked_req),
    .last_i (last_i),
    .grant  (grant)
  );

  assign waiting     = (state == I_RD) || (state == D_RD) || (state == D_WR);
  assign take_grant  = (state == IDLE) && (grant != 3'b000);
  assign timeout_hit = waiting && (wait_cnt == TIMEOUT_LAST);

  // Translate the one-hot grant into a requester id and its block address
  always_comb begin
    grant_id   = REQ_DRD;
    grant_addr = d_rd_addr;
    if (grant[REQ_I]) begin
      grant_id   = REQ_I;
      grant_addr = i_addr;
    end else if (grant[REQ_DWR]) begin
      grant_id   = REQ_DWR;
      grant_addr = d_wr_addr;
    end
  end

  // Next-state logic: grant from IDLE, wait for the matching valid, one DONE cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant[REQ_I]) begin
          state_next = I_RD;
        end else if (grant[REQ_DWR]) begin
          state_next = D_WR;
        end else if (grant[REQ_DRD]) begin
          state_next = D_RD;
        end
      end
      I_RD, D_RD: begin
        if (mem_read_valid) state_next = DONE;
      end
      D_WR: begin
        if (mem_write_valid) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Control registers: state, owner, fairness bit, post-completion mask, wait counter, error
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      cur_id   <= REQ_I;
      last_i   <= 1'b0;
      mask     <= 3'b000;
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      mask  <= (state == DONE) ? (3'b001 << cur_id) : 3'b000;
      if (take_grant) begin
        cur_id   <= grant_id;
        last_i   <= grant[REQ_I];
        wait_cnt <= '0;
      end else if (waiting && (wait_cnt != CNT_MAX)) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end

  // Data registers: address/write block latched at grant, read blocks captured on valid
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (take_grant) begin
        mem_addr <= blk_align(grant_addr);
        if (grant[REQ_DWR]) mem_wdata <= d_wdata;
      end
      if ((state == I_RD) && mem_read_valid) i_rdata <= mem_rdata;
      if ((state == D_RD) && mem_read_valid) d_rdata <= mem_rdata;
    end
  end

  assign mem_blk_read  = (state == I_RD) || (state == D_RD);
  assign mem_blk_write = (state == D_WR);
  assign i_done        = (state == DONE) && (cur_id == REQ_I);
  assign d_rd_done     = (state == DONE) && (cur_id == REQ_DRD);
  assign d_wr_done     = (state == DONE) && (cur_id == REQ_DWR);
  assign arb_idle      = !RESET || ((state == IDLE) && (masked_req == 3'b000));
  assign arb_err       = err_q || timeout_hit;

endmodule

// File: tb/tb_mem_block_arbiter.sv
// Self-checking bench for mem_block_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_mem_block_arbiter;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         i_req, d_rd_req, d_wr_req;
  logic [31:0]  i_addr, d_rd_addr, d_wr_addr;
  logic [255:0] d_wdata, mem_rdata;
  logic         mem_read_valid, mem_write_valid;
  logic         i_done, d_rd_done, d_wr_done;
  logic [255:0] i_rdata, d_rdata, mem_wdata;
  logic [31:0]  mem_addr;
  logic         mem_blk_read, mem_blk_write, arb_idle, arb_err;

  int checks   = 0;
  int failures = 0;

  mem_block_arbiter #(.TIMEOUT(64), .CNT_W(7)) dut (
    .CLK(CLK), .RESET(RESET),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_rd_req(d_rd_req), .d_wr_req(d_wr_req), .d_rd_addr(d_rd_addr), .d_wr_addr(d_wr_addr),
    .d_wdata(d_wdata), .d_rd_done(d_rd_done), .d_wr_done(d_wr_done), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_blk_read(mem_blk_read), .mem_blk_write(mem_blk_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_read_valid(mem_read_valid),
    .mem_write_valid(mem_write_valid), .arb_idle(arb_idle), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] global timeout");
  end

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic clear_inputs;
    i_req = 0; d_rd_req = 0; d_wr_req = 0;
    i_addr = 0; d_rd_addr = 0; d_wr_addr = 0; d_wdata = 0;
    mem_rdata = 0; mem_read_valid = 0; mem_write_valid = 0;
  endtask

  // Leaves time just after a rising edge with reset released; that cycle is "cycle 0"
  task automatic do_reset;
    clear_inputs();
    RESET = 0;
    @(posedge CLK);
    @(posedge CLK);
    #1 RESET = 1;
  endtask

  task automatic next_cycle;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    clear_inputs();
    RESET = 0;
    d_wr_req = 1;
    #2;
    checks++;
    if ({mem_blk_read, mem_blk_write, i_done, d_rd_done, d_wr_done} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: got %b want 00000", {mem_blk_read, mem_blk_write, i_done, d_rd_done, d_wr_done});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 256'h0 || i_rdata !== 256'h0 || d_rdata !== 256'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: mem_addr=%h want 0, data regs not all zero", mem_addr);
    end
    checks++;
    if (arb_idle !== 1'b1 || arb_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_flags: idle=%b err=%b want idle=1 err=0", arb_idle, arb_err);
    end
  endtask

  task automatic test_lone_i;
    logic [255:0] pat;
    pat = {32{8'hA5}};
    do_reset();
    i_req = 1; i_addr = 32'h0040_0123;
    @(negedge CLK);
    checks++;
    if (arb_idle !== 1'b0) begin
      failures++; $display("[TB] FAIL lone_i_busy: arb_idle=%b want 0", arb_idle);
    end
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      if (c == 4) begin mem_read_valid = 1; mem_rdata = pat; end
      @(negedge CLK);
      checks++;
      if (mem_addr !== 32'h0040_0120 || mem_blk_read !== 1'b1 || i_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL lone_i_wait c%0d: addr=%h rd=%b done=%b want 00400120 1 0", c, mem_addr, mem_blk_read, i_done);
      end
    end
    next_cycle();
    mem_read_valid = 0; mem_rdata = 0;
    @(negedge CLK);
    checks++;
    if (i_done !== 1'b1 || i_rdata !== pat || mem_blk_read !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lone_i_done: done=%b rd=%b rdata=%h want 1 0 a5..", i_done, mem_blk_read, i_rdata);
    end
    next_cycle();
    i_req = 0;
    @(negedge CLK);
    checks++;
    if (arb_idle !== 1'b1 || i_done !== 1'b0) begin
      failures++; $display("[TB] FAIL lone_i_after: idle=%b done=%b want 1 0", arb_idle, i_done);
    end
  endtask

  task automatic test_dwr_drd;
    logic [255:0] wd, rd;
    wd = rand256(); rd = rand256();
    do_reset();
    d_wr_req = 1; d_rd_req = 1;
    d_wr_addr = 32'h1234_567F; d_rd_addr = 32'h8765_4321; d_wdata = wd;
    next_cycle();
    mem_write_valid = 1;
    @(negedge CLK);
    checks++;
    if (mem_blk_write !== 1'b1 || mem_blk_read !== 1'b0 || mem_wdata !== wd || mem_addr !== 32'h1234_5660) begin
      failures++;
      $display("[TB] FAIL dwr_first: wr=%b rd=%b addr=%h want 1 0 12345660", mem_blk_write, mem_blk_read, mem_addr);
    end
    next_cycle();
    mem_write_valid = 0;
    @(negedge CLK);
    checks++;
    if (d_wr_done !== 1'b1 || d_rd_done !== 1'b0) begin
      failures++; $display("[TB] FAIL dwr_done: wr_done=%b rd_done=%b want 1 0", d_wr_done, d_rd_done);
    end
    next_cycle();
    d_wr_req = 0;
    @(negedge CLK);
    checks++;
    if (arb_idle !== 1'b0 || mem_blk_read !== 1'b0) begin
      failures++; $display("[TB] FAIL drd_pending: idle=%b rd=%b want 0 0", arb_idle, mem_blk_read);
    end
    next_cycle();
    mem_read_valid = 1; mem_rdata = rd;
    @(negedge CLK);
    checks++;
    if (mem_blk_read !== 1'b1 || mem_addr !== 32'h8765_4320) begin
      failures++; $display("[TB] FAIL drd_grant: rd=%b addr=%h want 1 87654320", mem_blk_read, mem_addr);
    end
    next_cycle();
    mem_read_valid = 0;
    @(negedge CLK);
    checks++;
    if (d_rd_done !== 1'b1 || d_wr_done !== 1'b0 || d_rdata !== rd) begin
      failures++;
      $display("[TB] FAIL drd_done: rd_done=%b wr_done=%b rdata=%h want 1 0 %h", d_rd_done, d_wr_done, d_rdata, rd);
    end
    next_cycle();
    d_rd_req = 0;
  endtask

  task automatic test_alternate;
    int  n;
    bit  exp_i;
    do_reset();
    i_req = 1; d_rd_req = 1; i_addr = $urandom; d_rd_addr = $urandom;
    n = 0;
    for (int c = 0; c < 200 && n < 6; c++) begin
      mem_read_valid = mem_blk_read;
      mem_rdata = rand256();
      @(negedge CLK);
      if (i_done || d_rd_done) begin
        exp_i = (n % 2 == 0);
        checks++;
        if (i_done !== exp_i || d_rd_done !== !exp_i) begin
          failures++;
          $display("[TB] FAIL alternate_%0d: i_done=%b d_rd_done=%b want %b %b", n, i_done, d_rd_done, exp_i, !exp_i);
        end
        n++;
      end
      next_cycle();
    end
    checks++;
    if (n != 6) begin
      failures++; $display("[TB] FAIL alternate_count: got %0d completions want 6", n);
    end
    clear_inputs();
  endtask

  task automatic test_triple;
    int order[3];
    int n;
    bit drop_i, drop_r, drop_w;
    order = '{0, 2, 1};
    do_reset();
    i_req = 1; d_rd_req = 1; d_wr_req = 1;
    i_addr = $urandom; d_rd_addr = $urandom; d_wr_addr = $urandom; d_wdata = rand256();
    n = 0; drop_i = 0; drop_r = 0; drop_w = 0;
    for (int c = 0; c < 100 && n < 3; c++) begin
      if (drop_i) i_req = 0;
      if (drop_r) d_rd_req = 0;
      if (drop_w) d_wr_req = 0;
      mem_read_valid = mem_blk_read;
      mem_write_valid = mem_blk_write;
      @(negedge CLK);
      if (i_done || d_rd_done || d_wr_done) begin
        checks++;
        if ({d_wr_done, d_rd_done, i_done} !== (3'b001 << order[n])) begin
          failures++;
          $display("[TB] FAIL triple_%0d: {wr,rd,i} done=%b want %b", n, {d_wr_done, d_rd_done, i_done}, 3'b001 << order[n]);
        end
        drop_i = drop_i | i_done; drop_r = drop_r | d_rd_done; drop_w = drop_w | d_wr_done;
        n++;
      end
      next_cycle();
    end
    checks++;
    if (n != 3) begin
      failures++; $display("[TB] FAIL triple_count: got %0d completions want 3", n);
    end
    clear_inputs();
  endtask

  task automatic test_timeout;
    logic [255:0] pat;
    pat = rand256();
    do_reset();
    i_req = 1; i_addr = $urandom;
    for (int c = 1; c <= 70; c++) begin
      next_cycle();
      mem_read_valid = (c == 70);
      if (c == 70) mem_rdata = pat;
      @(negedge CLK);
      if (c == 63) begin
        checks++;
        if (arb_err !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: err=%b want 0 at cycle 63", arb_err); end
      end
      if (c == 64) begin
        checks++;
        if (arb_err !== 1'b1) begin failures++; $display("[TB] FAIL timeout_set: err=%b want 1 at cycle 64", arb_err); end
      end
      if (c == 69) begin
        checks++;
        if (mem_blk_read !== 1'b1) begin failures++; $display("[TB] FAIL timeout_wait: rd=%b want 1", mem_blk_read); end
      end
    end
    next_cycle();
    mem_read_valid = 0;
    @(negedge CLK);
    checks++;
    if (i_done !== 1'b1 || i_rdata !== pat || arb_err !== 1'b1) begin
      failures++; $display("[TB] FAIL timeout_done: done=%b err=%b rdata=%h want 1 1 %h", i_done, arb_err, i_rdata, pat);
    end
    next_cycle();
    i_req = 0;
    @(negedge CLK);
    checks++;
    if (arb_err !== 1'b1 || arb_idle !== 1'b1) begin
      failures++; $display("[TB] FAIL timeout_sticky: err=%b idle=%b want 1 1", arb_err, arb_idle);
    end
  endtask

  task automatic test_reset_mid;
    do_reset();
    d_wr_req = 1; d_wr_addr = 32'hCAFE_BABE; d_wdata = rand256();
    next_cycle();
    @(negedge CLK);
    checks++;
    if (mem_blk_write !== 1'b1) begin failures++; $display("[TB] FAIL rmid_write: wr=%b want 1", mem_blk_write); end
    next_cycle();
    @(negedge CLK);
    #1 RESET = 0;
    #1;
    checks++;
    if (mem_blk_write !== 1'b0 || d_wr_done !== 1'b0 || arb_idle !== 1'b1 || mem_addr !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rmid_abort: wr=%b done=%b idle=%b addr=%h want 0 0 1 0", mem_blk_write, d_wr_done, arb_idle, mem_addr);
    end
    @(posedge CLK);
    #1;
    checks++;
    if (d_wr_done !== 1'b0 || mem_blk_write !== 1'b0) begin
      failures++; $display("[TB] FAIL rmid_held: done=%b wr=%b want 0 0", d_wr_done, mem_blk_write);
    end
    @(posedge CLK);
    #1 RESET = 1;
    @(negedge CLK);
    checks++;
    if (arb_idle !== 1'b0) begin failures++; $display("[TB] FAIL rmid_pending: idle=%b want 0", arb_idle); end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (mem_blk_write !== 1'b1 || mem_addr !== 32'hCAFE_BAA0) begin
      failures++; $display("[TB] FAIL rmid_regrant: wr=%b addr=%h want 1 cafebaa0", mem_blk_write, mem_addr);
    end
    clear_inputs();
  endtask

  task automatic test_hold_done;
    do_reset();
    i_req = 1; i_addr = $urandom;
    next_cycle();
    mem_read_valid = 1;
    next_cycle();
    mem_read_valid = 0;
    @(negedge CLK);
    checks++;
    if (i_done !== 1'b1) begin failures++; $display("[TB] FAIL hold_done: done=%b want 1", i_done); end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (mem_blk_read !== 1'b0 || arb_idle !== 1'b1 || i_done !== 1'b0) begin
      failures++; $display("[TB] FAIL hold_masked: rd=%b idle=%b done=%b want 0 1 0", mem_blk_read, arb_idle, i_done);
    end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (arb_idle !== 1'b0) begin failures++; $display("[TB] FAIL hold_unmask: idle=%b want 0", arb_idle); end
    next_cycle();
    @(negedge CLK);
    checks++;
    if (mem_blk_read !== 1'b1) begin failures++; $display("[TB] FAIL hold_regrant: rd=%b want 1", mem_blk_read); end
    clear_inputs();
  endtask

  // Transaction-level model: the bench decides each transaction's latency and predicts every cycle
  task automatic test_random;
    int phase, who, lat, mask_who, g;
    bit lim, dany;
    bit fin[3];
    bit pend[3];
    logic [31:0]  exp_addr;
    logic [255:0] exp_wd, exp_ri, exp_rd, rd_drv;
    do_reset();
    phase = 0; who = 0; lat = 0; mask_who = -1; lim = 0;
    exp_addr = 0; exp_wd = 0; exp_ri = 0; exp_rd = 0;
    fin = '{0, 0, 0};
    for (int c = 0; c < 600; c++) begin
      if (fin[0]) begin
        fin[0] = 0;
        if ($urandom_range(0, 1) == 0) i_req = 0; else i_addr = $urandom;
      end else if (!i_req && $urandom_range(0, 2) == 0) begin
        i_req = 1; i_addr = $urandom;
      end
      if (fin[1]) begin
        fin[1] = 0;
        if ($urandom_range(0, 1) == 0) d_rd_req = 0; else d_rd_addr = $urandom;
      end else if (!d_rd_req && $urandom_range(0, 2) == 0) begin
        d_rd_req = 1; d_rd_addr = $urandom;
      end
      if (fin[2]) begin
        fin[2] = 0;
        if ($urandom_range(0, 1) == 0) d_wr_req = 0; else begin d_wr_addr = $urandom; d_wdata = rand256(); end
      end else if (!d_wr_req && $urandom_range(0, 2) == 0) begin
        d_wr_req = 1; d_wr_addr = $urandom; d_wdata = rand256();
      end
      rd_drv = rand256();
      mem_rdata = rd_drv;
      mem_read_valid = 1'($urandom_range(0, 1));
      mem_write_valid = 1'($urandom_range(0, 1));
      if (phase == 1) begin
        if (who == 2) mem_write_valid = (lat == 0); else mem_read_valid = (lat == 0);
      end
      @(negedge CLK);
      checks++;
      if (arb_err !== 1'b0 || i_rdata !== exp_ri || d_rdata !== exp_rd) begin
        failures++; $display("[TB] FAIL rnd_hold c%0d: err=%b i_rdata/d_rdata differ from last captured blocks", c, arb_err);
      end
      case (phase)
        0: begin
          pend[0] = i_req && (mask_who != 0);
          pend[1] = d_rd_req && (mask_who != 1);
          pend[2] = d_wr_req && (mask_who != 2);
          dany = pend[1] | pend[2];
          checks++;
          if ({mem_blk_read, mem_blk_write, i_done, d_rd_done, d_wr_done} !== 5'b0 || arb_idle !== !(pend[0] | dany)) begin
            failures++;
            $display("[TB] FAIL rnd_idle c%0d: strobes=%b idle=%b want 00000 %b", c,
                     {mem_blk_read, mem_blk_write, i_done, d_rd_done, d_wr_done}, arb_idle, !(pend[0] | dany));
          end
          mask_who = -1;
          if (pend[0] || dany) begin
            if (pend[0] && (!dany || !lim)) g = 0; else g = pend[2] ? 2 : 1;
            who = g;
            lim = (g == 0);
            case (g)
              0: exp_addr = {i_addr[31:5], 5'b0};
              1: exp_addr = {d_rd_addr[31:5], 5'b0};
              default: begin exp_addr = {d_wr_addr[31:5], 5'b0}; exp_wd = d_wdata; end
            endcase
            lat = $urandom_range(0, 4);
            phase = 1;
          end
        end
        1: begin
          checks++;
          if ({mem_blk_read, mem_blk_write} !== {who != 2, who == 2} || mem_addr !== exp_addr) begin
            failures++;
            $display("[TB] FAIL rnd_active c%0d who=%0d: rd=%b wr=%b addr=%h want %b %b %h", c, who,
                     mem_blk_read, mem_blk_write, mem_addr, who != 2, who == 2, exp_addr);
          end
          checks++;
          if ({i_done, d_rd_done, d_wr_done, arb_idle} !== 4'b0 || (who == 2 && mem_wdata !== exp_wd)) begin
            failures++;
            $display("[TB] FAIL rnd_active_side c%0d: dones+idle=%b want 0000 or wdata wrong", c, {i_done, d_rd_done, d_wr_done, arb_idle});
          end
          if (lat == 0) begin
            if (who == 0) exp_ri = rd_drv;
            else if (who == 1) exp_rd = rd_drv;
            phase = 2;
          end else begin
            lat--;
          end
        end
        default: begin
          checks++;
          if ({i_done, d_rd_done, d_wr_done} !== {who == 0, who == 1, who == 2} ||
              {mem_blk_read, mem_blk_write, arb_idle} !== 3'b0) begin
            failures++;
            $display("[TB] FAIL rnd_done c%0d who=%0d: {i,rd,wr}=%b strobes+idle=%b want %b 000", c, who,
                     {i_done, d_rd_done, d_wr_done}, {mem_blk_read, mem_blk_write, arb_idle}, {who == 0, who == 1, who == 2});
          end
          fin[who] = 1;
          mask_who = who;
          phase = 0;
        end
      endcase
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    $display("[TB] mem_block_arbiter bench start");
    test_reset();
    test_lone_i();
    test_dwr_drd();
    test_alternate();
    test_triple();
    test_hold_done();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_block_arbiter.md
# mem_block_arbiter

Shares the single main-memory block port between the instruction-cache refill path (iBlkRead/block_read_fIM) and the data-cache refill/writeback path (dBlkRead/dBlkWrite/block_read_fDM/block_write_2DM). It sits between the future I/D caches and the MIPS top-level memory pins. It serialises one 256-bit block transaction at a time, orders D-side writebacks ahead of D-side refills, and alternates fairly between the I and D sides on conflict. It also exposes an idle flag so SYS can be held until memory traffic drains.

## Interface
Parameters:
- TIMEOUT, 64: maximum cycles a memory transaction may wait for valid before `arb_err` sets.
- CNT_W, 7: width of the wait counter; must hold TIMEOUT.

Ports:
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- i_req  in  1  I-cache block-read request, level; held until `i_done`.
- i_addr  in  32  I block address, bits [4:0] ignored.
- i_done  out  1  one-cycle pulse, `i_rdata` valid.
- i_rdata  out  256  I refill block.
- d_rd_req  in  1  D-cache block-read request, level.
- d_wr_req  in  1  D-cache block-write (writeback) request, level.
- d_rd_addr, d_wr_addr  in  32 each  D addresses, bits [4:0] ignored.
- d_wdata  in  256  writeback block.
- d_rd_done, d_wr_done  out  1 each  one-cycle completion pulses.
- d_rdata  out  256  D refill block.
- mem_addr  out  32  block address to memory, low 5 bits zero.
- mem_blk_read, mem_blk_write  out  1 each  held high for the whole transaction.
- mem_wdata  out  256  write block.
- mem_rdata  in  256  read block.
- mem_read_valid, mem_write_valid  in  1 each  completion from memory.
- arb_idle  out  1  no transaction in progress and no grant pending.
- arb_err  out  1  sticky timeout flag.

## Operation
- Reset values: all outputs 0, except `arb_idle`=1. State IDLE, `last_i`=0, wait counter 0.
- FSM states: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE priority:
  - `d_wr_req` beats `d_rd_req`.
  - If an I request and any D request are both pending, the grant goes to the side not granted last. `last_i`=1 means I was last.
  - A lone request is granted immediately.
- On grant:
  - Register `mem_addr` = {addr[31:5],5'b0}.
  - For D_WR, also register `mem_wdata`.
  - Assert the matching `mem_blk_*` from the next cycle onward.
  - Update `last_i`.
- I_RD/D_RD: wait for `mem_read_valid`, then capture `mem_rdata` into `i_rdata` or `d_rdata` and go to DONE.
- D_WR: wait for `mem_write_valid`, then go to DONE.
- In the DONE cycle:
  - Strobes are low.
  - The matching done pulse is high.
  - Next state is IDLE.
  - The requester that just completed is masked in IDLE for the following cycle, so a req still high in the DONE cycle is not re-granted.
- Valid inputs are ignored in IDLE and DONE. A valid of the wrong type (write valid while reading, or read valid while writing) is ignored.
- Wait counter:
  - Clears on grant and increments each cycle in I_RD/D_RD/D_WR, saturating at 2^CNT_W−1.
  - When it reaches TIMEOUT, `arb_err` sets and stays set until reset. The transaction keeps waiting.
- `arb_rdata` registers hold their value until the next capture.
- RESET low at any time forces reset values immediately. Any in-flight transaction is abandoned, with no done pulse.

## Timing
- Request high in IDLE at cycle 0: `mem_blk_*` and `mem_addr` valid at cycle 1.
- Valid at cycle N: done pulse and data at cycle N+1. IDLE at N+2, so the earliest next strobe is at N+3.
- Minimum transaction, with valid at cycle 1: strobe at 1, done at 2.
- `arb_idle`=1 only in IDLE with no unmasked request pending.
- Simultaneous `d_wr_req`+`d_rd_req`+`i_req` with `last_i`=0: I granted first, then D_WR, then D_RD.

## Structure
- Package `mem_arb_pkg`:
  - State enum.
  - `BLK_W`=256, `BLK_OFF`=5.
  - Requester-id enum {REQ_I, REQ_DRD, REQ_DWR}.
- One combinational sub-module, `mem_arb_pick`: takes the masked requests and `last_i`, and returns a one-hot grant.
- FSM, counter and data registers live in `mem_block_arbiter`.

## Test plan
- Lone `i_req`, addr 0x0040_0123, valid at cycle 4 with rdata pattern A5…:
  - `mem_addr`=0x0040_0120 and `mem_blk_read`=1 during cycles 1-4.
  - `i_done` and `i_rdata`=A5… at cycle 5.
- `d_wr_req`+`d_rd_req` both high at cycle 0:
  - `mem_blk_write` granted first with `mem_wdata`=`d_wdata`.
  - `d_wr_done`, then the read is granted.
  - `d_rd_done` follows; the two done pulses are never simultaneous.
- I and D held continuously for 6 transactions from reset: grant sequence I, D, I, D, I, D.
- No valid for 64 cycles:
  - `arb_err`=1 at the 64th wait cycle.
  - A valid at cycle 70 still completes normally.
  - `arb_err` stays 1.
- RESET low in the middle of D_WR:
  - Strobes drop immediately, no `d_wr_done`, `arb_idle`=1.
  - After release, a held `d_wr_req` is regranted.
- Requester keeps req high through DONE: no regrant in the cycle after DONE, and `arb_idle`=1 for that cycle.
